// File: rtl/control_sequencer.sv
// Purpose: hardwired control sequencer issuing datapath strobes for fetch/decode/execute (T0..T6) with HALT.
// Latency: outputs are a Moore decode of the present state (and IR from T3 on); one state per clock.
// Backpressure: none; Stop is honoured only at instruction boundaries, HALT is left only through reset.
module control_sequencer (
    input  logic        Clock,
    input  logic        Clear_n,
    input  logic [31:0] IR,
    input  logic        Stop,
    output logic        PCout,
    output logic        MDRout,
    output logic        Zhighout,
    output logic        Zlowout,
    output logic        HIout,
    output logic        LOout,
    output logic        MARin,
    output logic        PCin,
    output logic        MDRin,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        HIin,
    output logic        LOin,
    output logic        IncPC,
    output logic        Read,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic [4:0]  alu_op,
    output logic        Run
);

    typedef enum logic [3:0] {
        RESET_ST = 4'd0,
        T0       = 4'd1,
        T1       = 4'd2,
        T2       = 4'd3,
        T3       = 4'd4,
        T4       = 4'd5,
        T5       = 4'd6,
        T6       = 4'd7,
        HALT     = 4'd8
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [4:0] w_opcode;
    logic       w_rtype;
    logic       w_muldiv;
    logic       w_halt_op;
    logic       w_unused_ir;

    // Register fields are consumed by the datapath through Gra/Grb/Grc; only the opcode matters here.
    assign w_opcode    = IR[31:27];
    assign w_unused_ir = ^IR[26:0];
    assign w_rtype     = (w_opcode >= 5'd3) && (w_opcode <= 5'd11);
    assign w_muldiv    = (w_opcode == 5'd14) || (w_opcode == 5'd15);
    assign w_halt_op   = (w_opcode == 5'd27);

    // State register; reset forces RESET_ST immediately so every decoded output drops at once.
    always_ff @(posedge Clock or negedge Clear_n) begin
        if (!Clear_n) begin
            r_state <= RESET_ST;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and Moore output decode; every strobe defaults low and only the listed ones rise.
    always_comb begin
        PCout    = 1'b0;
        MDRout   = 1'b0;
        Zhighout = 1'b0;
        Zlowout  = 1'b0;
        HIout    = 1'b0;
        LOout    = 1'b0;
        MARin    = 1'b0;
        PCin     = 1'b0;
        MDRin    = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        Zin      = 1'b0;
        HIin     = 1'b0;
        LOin     = 1'b0;
        IncPC    = 1'b0;
        Read     = 1'b0;
        Gra      = 1'b0;
        Grb      = 1'b0;
        Grc      = 1'b0;
        Rin      = 1'b0;
        Rout     = 1'b0;
        alu_op   = 5'b00000;
        Run      = 1'b0;
        w_next   = r_state;
        case (r_state)
            RESET_ST: begin
                // Stop is deliberately ignored on the way out of reset.
                w_next = T0;
            end
            T0: begin
                Run    = 1'b1;
                PCout  = 1'b1;
                MARin  = 1'b1;
                IncPC  = 1'b1;
                Zin    = 1'b1;
                w_next = T1;
            end
            T1: begin
                Run     = 1'b1;
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
                w_next  = T2;
            end
            T2: begin
                Run    = 1'b1;
                MDRout = 1'b1;
                IRin   = 1'b1;
                w_next = T3;
            end
            T3: begin
                Run = 1'b1;
                if (w_rtype || w_muldiv) begin
                    Grb    = 1'b1;
                    Rout   = 1'b1;
                    Yin    = 1'b1;
                    w_next = T4;
                end else if (w_halt_op) begin
                    w_next = HALT;
                end else begin
                    // nop and every unassigned opcode end the instruction here.
                    w_next = Stop ? HALT : T0;
                end
            end
            T4: begin
                Run    = 1'b1;
                Grc    = 1'b1;
                Rout   = 1'b1;
                Zin    = 1'b1;
                alu_op = w_opcode;
                w_next = T5;
            end
            T5: begin
                Run     = 1'b1;
                Zlowout = 1'b1;
                if (w_muldiv) begin
                    LOin   = 1'b1;
                    w_next = T6;
                end else begin
                    Gra    = 1'b1;
                    Rin    = 1'b1;
                    w_next = Stop ? HALT : T0;
                end
            end
            T6: begin
                Run      = 1'b1;
                Zhighout = 1'b1;
                HIin     = 1'b1;
                w_next   = Stop ? HALT : T0;
            end
            HALT: begin
                w_next = HALT;
            end
            default: begin
                w_next = RESET_ST;
            end
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Purpose: self-checking bench for control_sequencer: directed vector table plus randomized instruction stream.
// Latency: inputs driven just after the falling edge, outputs sampled at the falling edge (mid-cycle).
// Backpressure: none; bench waits are bounded by a global watchdog.
module tb_control_sequencer;

    logic        Clock;
    logic        Clear_n;
    logic [31:0] IR;
    logic        Stop;
    logic        PCout, MDRout, Zhighout, Zlowout, HIout, LOout;
    logic        MARin, PCin, MDRin, IRin, Yin, Zin, HIin, LOin;
    logic        IncPC, Read, Gra, Grb, Grc, Rin, Rout;
    logic [4:0]  alu_op;
    logic        Run;

    int checks = 0;
    int errors = 0;
    bit t0_seen = 1'b0;

    control_sequencer dut (
        .Clock(Clock), .Clear_n(Clear_n), .IR(IR), .Stop(Stop),
        .PCout(PCout), .MDRout(MDRout), .Zhighout(Zhighout), .Zlowout(Zlowout),
        .HIout(HIout), .LOout(LOout), .MARin(MARin), .PCin(PCin), .MDRin(MDRin),
        .IRin(IRin), .Yin(Yin), .Zin(Zin), .HIin(HIin), .LOin(LOin),
        .IncPC(IncPC), .Read(Read), .Gra(Gra), .Grb(Grb), .Grc(Grc),
        .Rin(Rin), .Rout(Rout), .alu_op(alu_op), .Run(Run)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    // Observed word: {alu_op, Run, strobes}
    logic [26:0] obs;
    assign obs = {alu_op, Run, Rout, Rin, Grc, Grb, Gra, Read, IncPC, LOin, HIin, Zin, Yin,
                  IRin, MDRin, PCin, MARin, LOout, HIout, Zlowout, Zhighout, MDRout, PCout};

    localparam logic [26:0] B_PCOUT = 27'd1 << 0;
    localparam logic [26:0] B_MDROUT = 27'd1 << 1;
    localparam logic [26:0] B_ZHIGH = 27'd1 << 2;
    localparam logic [26:0] B_ZLOW = 27'd1 << 3;
    localparam logic [26:0] B_MARIN = 27'd1 << 6;
    localparam logic [26:0] B_PCIN = 27'd1 << 7;
    localparam logic [26:0] B_MDRIN = 27'd1 << 8;
    localparam logic [26:0] B_IRIN = 27'd1 << 9;
    localparam logic [26:0] B_YIN = 27'd1 << 10;
    localparam logic [26:0] B_ZIN = 27'd1 << 11;
    localparam logic [26:0] B_HIIN = 27'd1 << 12;
    localparam logic [26:0] B_LOIN = 27'd1 << 13;
    localparam logic [26:0] B_INCPC = 27'd1 << 14;
    localparam logic [26:0] B_READ = 27'd1 << 15;
    localparam logic [26:0] B_GRA = 27'd1 << 16;
    localparam logic [26:0] B_GRB = 27'd1 << 17;
    localparam logic [26:0] B_GRC = 27'd1 << 18;
    localparam logic [26:0] B_RIN = 27'd1 << 19;
    localparam logic [26:0] B_ROUT = 27'd1 << 20;
    localparam logic [26:0] B_RUN = 27'd1 << 21;
    localparam logic [26:0] W_T0 = B_PCOUT | B_MARIN | B_INCPC | B_ZIN | B_RUN;

    // Opcode class: 0 R-type, 1 mul/div, 2 halt, 3 nop/illegal
    function automatic int op_class(input logic [4:0] op);
        if (op >= 5'd3 && op <= 5'd11) return 0;
        if (op == 5'd14 || op == 5'd15) return 1;
        if (op == 5'd27) return 2;
        return 3;
    endfunction

    function automatic int model_len(input logic [31:0] ir);
        case (op_class(ir[31:27]))
            0: return 6;
            1: return 7;
            default: return 4;
        endcase
    endfunction

    // Expected output word for cycle k (0 = T0) of an instruction
    function automatic logic [26:0] model_word(input logic [31:0] ir, input int k);
        int c;
        logic [26:0] alu_field;
        c = op_class(ir[31:27]);
        alu_field = {ir[31:27], 22'd0};
        case (k)
            0: return W_T0;
            1: return B_ZLOW | B_PCIN | B_READ | B_MDRIN | B_RUN;
            2: return B_MDROUT | B_IRIN | B_RUN;
            3: return (c <= 1) ? (B_GRB | B_ROUT | B_YIN | B_RUN) : B_RUN;
            4: return B_GRC | B_ROUT | B_ZIN | B_RUN | alu_field;
            5: return (c == 0) ? (B_ZLOW | B_GRA | B_RIN | B_RUN) : (B_ZLOW | B_LOIN | B_RUN);
            6: return B_ZHIGH | B_HIIN | B_RUN;
            default: return 27'd0;
        endcase
    endfunction

    task automatic check(input logic [26:0] exp, input string name);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, obs, exp);
        end
    endtask

    task automatic do_reset();
        Clear_n = 1'b0;
        #1;
        check(27'd0, "reset_async");
        @(negedge Clock);
        check(27'd0, "reset_hold");
        Clear_n = 1'b1;
        t0_seen = 1'b0;
    endtask

    // Runs one instruction and checks every cycle plus the following boundary (T0 or HALT).
    task automatic run_instr(input logic [31:0] ir, input bit rnd, input bit stop_final,
                             input int stop_from, input int len, input bit halt_exp,
                             input int abort_at, input string tag);
        int k0;
        if (t0_seen) begin
            Stop = (len == 1) ? stop_final : ((stop_from == 0) ? 1'b1 : (rnd ? 1'($urandom_range(0, 1)) : 1'b0));
            IR   = rnd ? $urandom : ir;
            k0   = 1;
        end else begin
            Stop = 1'b0;
            IR   = rnd ? $urandom : ir;
            k0   = 0;
        end
        for (int k = k0; k < len; k++) begin
            @(negedge Clock);
            check(model_word(ir, k), $sformatf("%s_cyc%0d", tag, k));
            if (k == abort_at) begin
                do_reset();
                return;
            end
            if (k == len - 1) Stop = stop_final;
            else if (stop_from >= 0 && k >= stop_from) Stop = 1'b1;
            else Stop = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            IR = (rnd && (k + 1) < 3) ? $urandom : ir;
        end
        @(negedge Clock);
        if (halt_exp) begin
            check(27'd0, {tag, "_enter_halt"});
            for (int h = 0; h < 20; h++) begin
                Stop = 1'($urandom_range(0, 1));
                @(negedge Clock);
                check(27'd0, {tag, "_halt_hold"});
            end
            do_reset();
        end else begin
            check(W_T0, {tag, "_next_t0"});
            t0_seen = 1'b1;
        end
    endtask

    typedef struct {
        logic [31:0] ir;
        bit          stop_final;
        int          stop_from;
        int          len;
        bit          halt;
        int          abort_at;
    } vec_t;

    vec_t tbl[14];

    initial begin
        logic [31:0] ir;
        logic [4:0]  op;
        logic [4:0]  legal_ops[11];
        bit          sf;

        tbl[0]  = '{32'h28918000, 1'b0, -1, 6, 1'b0, -1};
        tbl[1]  = '{32'h41918000, 1'b0, -1, 6, 1'b0, -1};
        tbl[2]  = '{{5'b01110, 27'h0123456}, 1'b0, -1, 7, 1'b0, -1};
        tbl[3]  = '{{5'b01111, 27'h7654321}, 1'b0, -1, 7, 1'b0, -1};
        tbl[4]  = '{{5'b11010, 27'h0000000}, 1'b0, -1, 4, 1'b0, -1};
        tbl[5]  = '{{5'b00000, 27'h1111111}, 1'b0, -1, 4, 1'b0, -1};
        tbl[6]  = '{{5'b11111, 27'h2222222}, 1'b0, -1, 4, 1'b0, -1};
        tbl[7]  = '{{5'b00011, 27'h3333333}, 1'b0, -1, 6, 1'b0, -1};
        tbl[8]  = '{{5'b01011, 27'h4444444}, 1'b0, -1, 6, 1'b0, -1};
        tbl[9]  = '{{5'b01100, 27'h5555555}, 1'b0, -1, 4, 1'b0, -1};
        tbl[10] = '{32'h28918000, 1'b1, 2, 6, 1'b1, -1};
        tbl[11] = '{32'h28918000, 1'b0, -1, 6, 1'b0, 4};
        tbl[12] = '{{5'b01110, 27'h0abcdef}, 1'b1, -1, 7, 1'b1, -1};
        tbl[13] = '{{5'b11011, 27'h0000000}, 1'b0, -1, 4, 1'b1, -1};

        legal_ops = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11, 5'd14, 5'd15};

        Clear_n = 1'b1;
        IR      = 32'd0;
        Stop    = 1'b0;
        @(negedge Clock);
        do_reset();

        for (int i = 0; i < 14; i++) begin
            run_instr(tbl[i].ir, 1'b0, tbl[i].stop_final, tbl[i].stop_from, tbl[i].len,
                      tbl[i].halt, tbl[i].abort_at, $sformatf("vec%0d", i));
        end

        for (int n = 0; n < 80; n++) begin
            case ($urandom_range(0, 5))
                0:       op = 5'($urandom_range(0, 31));
                1:       op = ($urandom_range(0, 1) == 0) ? 5'd26 : 5'd27;
                default: op = legal_ops[$urandom_range(0, 10)];
            endcase
            ir = {op, 27'($urandom)};
            sf = ($urandom_range(0, 9) == 0);
            run_instr(ir, 1'b1, sf, -1, model_len(ir),
                      (op_class(op) == 2) || sf, -1, $sformatf("rnd%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 The block SHALL have no parameters; opcode map and state encoding are fixed by this document.
REQ-002 Clock  input  1  system clock; all state changes on its rising edge.
REQ-003 Clear_n  input  1  reset; one clock, and reset is asynchronous and active-low.
REQ-004 IR  input  32  instruction register contents from the datapath: IR[31:27] opcode, IR[26:23] Ra, IR[22:19] Rb, IR[18:15] Rc.
REQ-005 Stop  input  1  level request to halt at the next instruction boundary.
REQ-006 PCout, MDRout, Zhighout, Zlowout, HIout, LOout  output  1 each  bus-drive strobes to the datapath.
REQ-007 MARin, PCin, MDRin, IRin, Yin, Zin, HIin, LOin  output  1 each  register-load strobes.
REQ-008 IncPC, Read  output  1 each  PC-increment select and memory-read strobe.
REQ-009 Gra, Grb, Grc, Rin, Rout  output  1 each  register-field select and general-register load/drive.
REQ-010 alu_op  output  5  ALU operation code.
REQ-011 Run  output  1  high while the sequencer is executing and low in RESET_ST and HALT.

Function
REQ-012 States SHALL be RESET_ST, T0, T1, T2, T3, T4, T5, T6 and HALT, with exactly one state per clock cycle.
REQ-013 Outputs SHALL be Moore-decoded from the present state and IR; every strobe not listed for a state SHALL be 0, and alu_op SHALL be 5'b00000 outside T4.
REQ-014 T0 SHALL assert PCout, MARin, IncPC and Zin.
REQ-015 T1 SHALL assert Zlowout, PCin, Read and MDRin.
REQ-016 T2 SHALL assert MDRout and IRin.
REQ-017 The opcode classes SHALL be:
- R-type: 00011 through 01011 (add, sub, and, or, shr, shra, shl, ror, rol).
- mul: 01110.
- div: 01111.
- nop: 11010.
- halt: 11011.
- all other codes: illegal, treated as nop.
REQ-018 T3 for R-type, mul and div SHALL assert Grb, Rout and Yin.
REQ-019 T3 for nop or illegal SHALL assert nothing, and the next state SHALL be T0 (or HALT per REQ-024).
REQ-020 T3 for halt SHALL assert nothing, and the next state SHALL be HALT.
REQ-021 T4 SHALL assert Grc, Rout and Zin, with alu_op = IR[31:27].
REQ-022 T5 for R-type SHALL assert Zlowout, Gra and Rin, then go to T0. T5 for mul/div SHALL assert Zlowout and LOin, then go to T6.
REQ-023 T6 SHALL assert Zhighout and HIin, then go to T0.
REQ-024 On any transition into T0, Stop SHALL be sampled; if Stop=1 the next state SHALL be HALT instead of T0. Stop SHALL never abort an instruction mid-sequence.
REQ-025 HALT SHALL assert no strobes, hold Run=0, and be left only through reset.
REQ-026 IR SHALL be treated as valid from T3 onward; decode in T0-T2 SHALL NOT depend on IR.
REQ-027 Instruction length SHALL be:
- R-type: 6 cycles.
- mul/div: 7 cycles.
- nop/illegal: 4 cycles.
- halt: 4 cycles, then HALT.
REQ-028 No two bus-drive strobes (REQ-006 set plus Rout) SHALL ever be high in the same cycle.

Reset
REQ-029 Clear_n=0 SHALL immediately force RESET_ST, all outputs to 0, alu_op=0 and Run=0, regardless of the present state.
REQ-030 The first rising Clock edge with Clear_n=1 SHALL move RESET_ST to T0 with Run=1 (Stop is not sampled on this transition).
REQ-031 Reset asserted mid-instruction SHALL abort it with no further Rin, HIin or LOin pulse.

Verification
REQ-032 Reset release with IR=32'h28918000: T0-T5 strobes exactly per REQ-014..022, alu_op=5'b00101 only in T4, and Gra+Rin in cycle 6, then T0.
REQ-033 IR=32'h41918000 (shra): alu_op=5'b01000 in T4 and a 6-cycle instruction.
REQ-034 IR opcode 01110 (mul): T5 Zlowout+LOin, T6 Zhighout+HIin, no Rin pulse, 7 cycles.
REQ-035 IR opcode 11011: after T3 enters HALT; Run=0 and all strobes stay 0 for 20 cycles.
REQ-036 Stop=1 pulsed during T2 of an R-type and held to T5: instruction completes, then HALT instead of T0.
REQ-037 Clear_n dropped mid-T4: outputs are 0 asynchronously before the next edge; after release, the sequence restarts at T0.
